// File: rtl/cnn_fc_pkg.sv
// Shared definitions for the fully-connected layer weight path:
// default geometry, loader FSM states and the checksum update rule.
package cnn_fc_pkg;

    localparam int DW_DEF        = 24;
    localparam int AW_DEF        = 10;
    localparam int NUM_WORDS_DEF = 96;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_READ   = 3'd2,
        S_DRAIN  = 3'd3,
        S_CHECK  = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    // Checksum step: the word is mixed with its address so that swapped
    // or misaddressed words change the sum. Callers zero-extend into 64 bits
    // and truncate the result to their accumulator width.
    function automatic logic [63:0] csum_update(input logic [63:0] sum,
                                                input logic [63:0] data,
                                                input logic [63:0] addr);
        return sum + (data ^ addr);
    endfunction

endpackage

// File: rtl/cnn_fc_csum_acc.sv
// Running checksum accumulator. o_sum already includes the contribution of
// the word presented this cycle, so a consumer can compare the complete sum
// in the same cycle the last word arrives.
module cnn_fc_csum_acc
    import cnn_fc_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int CSW = DW + 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clear,
    input  logic           i_en,
    input  logic [DW-1:0]  i_data,
    input  logic [AW-1:0]  i_addr,
    output logic [CSW-1:0] o_sum
);

    logic [CSW-1:0] r_sum;
    logic [CSW-1:0] w_sum_upd;

    assign w_sum_upd = CSW'(csum_update(64'(r_sum), 64'(i_data), 64'(i_addr)));
    assign o_sum     = i_en ? w_sum_upd : r_sum;

    // Accumulate enabled words modulo 2^CSW; clear wins over accumulate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_en) begin
            r_sum <= w_sum_upd;
        end
    end

endmodule

// File: rtl/cnn_fc_weight_loader.sv
// Weight-memory initiator for the FC layer: streams words into RAM addresses
// 0..NUM_WORDS-1, optionally reads them all back and compares checksums.
module cnn_fc_weight_loader
    import cnn_fc_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          START,
    input  logic          VERIFY_EN,
    input  logic          ABORT,
    input  logic          WIN_VALID,
    input  logic [DW-1:0] WIN_DATA,
    output logic          WIN_READY,
    output logic          VECTOR_W_WEN,
    output logic          VECTOR_W_REN,
    output logic [AW-1:0] VECTOR_W_ADDR,
    output logic [DW-1:0] VECTOR_W_WDATA,
    input  logic [DW-1:0] VECTOR_W_RDATA,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERROR
);

    localparam int CSW = DW + 8;
    localparam int CW  = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wcnt;
    logic [CW-1:0]   r_rcnt;
    logic            r_verify;
    logic            r_wen;
    logic            r_ren;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_ren_d;
    logic [AW-1:0]   r_addr_d;
    logic            r_done;
    logic            r_error;
    logic            w_start;
    logic            w_hs;
    logic            w_rd;
    logic [CSW-1:0]  w_wcsum;
    logic [CSW-1:0]  w_rcsum;

    assign WIN_READY      = (r_state == S_LOAD);
    assign BUSY           = (r_state != S_IDLE);
    assign DONE           = r_done;
    assign ERROR          = r_error;
    assign VECTOR_W_WEN   = r_wen;
    assign VECTOR_W_REN   = r_ren;
    assign VECTOR_W_ADDR  = r_addr;
    assign VECTOR_W_WDATA = r_wdata;

    // ABORT suppresses the handshake and the read issue in the cycle it is seen.
    assign w_start = (r_state == S_IDLE) && START;
    assign w_hs    = (r_state == S_LOAD) && WIN_VALID && !ABORT;
    assign w_rd    = (r_state == S_READ) && !ABORT;

    // Write-side checksum follows accepted upstream words and their addresses.
    cnn_fc_csum_acc #(.DW(DW), .AW(AW), .CSW(CSW)) u_wcsum (
        .i_clk   (CLK),
        .i_rst_n (RSTn),
        .i_clear (w_start),
        .i_en    (w_hs),
        .i_data  (WIN_DATA),
        .i_addr  (r_wcnt[AW-1:0]),
        .o_sum   (w_wcsum)
    );

    // Read-side checksum follows RAM data qualified by the delayed read strobe.
    cnn_fc_csum_acc #(.DW(DW), .AW(AW), .CSW(CSW)) u_rcsum (
        .i_clk   (CLK),
        .i_rst_n (RSTn),
        .i_clear (w_start),
        .i_en    (r_ren_d),
        .i_data  (VECTOR_W_RDATA),
        .i_addr  (r_addr_d),
        .o_sum   (w_rcsum)
    );

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; ABORT returns to IDLE from every active phase but FINISH.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (ABORT)                         w_next = S_IDLE;
                else if (w_hs && (r_wcnt == LAST)) w_next = r_verify ? S_READ : S_FINISH;
            end
            S_READ: begin
                if (ABORT)               w_next = S_IDLE;
                else if (r_rcnt == LAST) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_next = ABORT ? S_IDLE : S_CHECK;
            end
            S_CHECK: begin
                w_next = ABORT ? S_IDLE : S_FINISH;
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counters and the verify flag latched at START.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_verify <= 1'b0;
        end else if (w_start) begin
            r_wcnt   <= '0;
            r_rcnt   <= '0;
            r_verify <= VERIFY_EN;
        end else begin
            if (w_hs) r_wcnt <= r_wcnt + 1'b1;
            if (w_rd) r_rcnt <= r_rcnt + 1'b1;
        end
    end

    // Registered RAM port; address and write data hold when idle or stalled.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_hs;
            r_ren <= w_rd;
            if (w_hs) begin
                r_addr  <= r_wcnt[AW-1:0];
                r_wdata <= WIN_DATA;
            end else if (w_rd) begin
                r_addr  <= r_rcnt[AW-1:0];
            end
        end
    end

    // One-cycle delayed read strobe and address, aligned with returning RDATA.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_ren_d  <= 1'b0;
            r_addr_d <= '0;
        end else begin
            r_ren_d  <= r_ren;
            r_addr_d <= r_addr;
        end
    end

    // DONE pulse after FINISH; ERROR is sticky until the next accepted START.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
            if (w_start) begin
                r_error <= 1'b0;
            end else if ((r_state == S_CHECK) && !ABORT) begin
                r_error <= (w_rcsum != w_wcsum);
            end
        end
    end

endmodule

// File: tb/tb_cnn_fc_weight_loader.sv
// Self-checking bench for cnn_fc_weight_loader with a behavioural RAM.
module tb_cnn_fc_weight_loader;

    localparam int DW  = 24;
    localparam int AW  = 10;
    localparam int N   = 96;
    localparam int CSW = DW + 8;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          START;
    logic          VERIFY_EN;
    logic          ABORT;
    logic          WIN_VALID;
    logic [DW-1:0] WIN_DATA;
    logic          WIN_READY;
    logic          WEN;
    logic          REN;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] WDATA;
    logic [DW-1:0] RDATA;
    logic          BUSY;
    logic          DONE;
    logic          ERROR;

    int nAssert = 0;
    int nFail   = 0;
    int cyc     = 0;
    int startCyc;
    int bothCnt = 0;
    int wBase, rBase, dBase;
    logic flip;

    logic [DW-1:0] words [N];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            hsCyc [$];
    int            wrAddr [$];
    logic [DW-1:0] wrData [$];
    int            wrCyc [$];
    int            rdAddr [$];
    int            rdCyc [$];
    int            doneCyc [$];
    logic          doneErr [$];

    // 100 MHz-style free-running clock.
    always #5 CLK = ~CLK;

    // Cycle counter used to timestamp every observed event.
    always @(posedge CLK) cyc <= cyc + 1;

    cnn_fc_weight_loader #(.DW(DW), .AW(AW), .NUM_WORDS(N)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .START          (START),
        .VERIFY_EN      (VERIFY_EN),
        .ABORT          (ABORT),
        .WIN_VALID      (WIN_VALID),
        .WIN_DATA       (WIN_DATA),
        .WIN_READY      (WIN_READY),
        .VECTOR_W_WEN   (WEN),
        .VECTOR_W_REN   (REN),
        .VECTOR_W_ADDR  (ADDR),
        .VECTOR_W_WDATA (WDATA),
        .VECTOR_W_RDATA (RDATA),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .ERROR          (ERROR)
    );

    // Ideal weight RAM with one-cycle read latency; optionally corrupts bit 0 of address 37.
    always @(posedge CLK) begin
        if (WEN) mem[ADDR] <= WDATA;
        if (REN) RDATA <= mem[ADDR] ^ ((flip && ADDR == AW'(37)) ? DW'(1) : DW'(0));
    end

    // Passive monitor logging RAM-port activity and DONE pulses mid-cycle.
    always @(negedge CLK) begin
        if (WEN === 1'b1) begin
            wrAddr.push_back(int'(ADDR));
            wrData.push_back(WDATA);
            wrCyc.push_back(cyc);
        end
        if (REN === 1'b1) begin
            rdAddr.push_back(int'(ADDR));
            rdCyc.push_back(cyc);
        end
        if (DONE === 1'b1) begin
            doneCyc.push_back(cyc);
            doneErr.push_back(ERROR);
        end
        if (WEN === 1'b1 && REN === 1'b1) bothCnt++;
    end

    // Single comparison point: counts and reports every mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Every output packed together; all must read zero under reset.
    function automatic logic [63:0] outVec();
        return 64'({WEN, REN, ADDR, WDATA, BUSY, DONE, ERROR, WIN_READY});
    endfunction

    // Fresh random weight set for the next load.
    task automatic genWords();
        for (int i = 0; i < N; i++) words[i] = DW'($urandom);
    endtask

    // Remember where the monitor logs stand so each test sees only its own events.
    task automatic markLogs();
        wBase = wrAddr.size();
        rBase = rdAddr.size();
        dBase = doneCyc.size();
        hsCyc.delete();
    endtask

    // Pulse START for one cycle with the requested verify mode.
    task automatic doStart(input logic v);
        START     = 1'b1;
        VERIFY_EN = v;
        startCyc  = cyc;
        tick();
        START     = 1'b0;
        VERIFY_EN = 1'b0;
    endtask

    // Offer words[0..nWords-1] upstream; mode 0 = always valid, 1 = random stalls.
    task automatic applyStimulus(input int mode, input int nWords);
        int k = 0;
        int guard = 0;
        while (k < nWords && guard < 4000) begin
            WIN_VALID = (mode == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            WIN_DATA  = words[k];
            if (WIN_VALID && WIN_READY) begin
                hsCyc.push_back(cyc);
                k++;
            end
            tick();
            guard++;
        end
        WIN_VALID = 1'b0;
        checkOutput("handshake_count", 64'(k), 64'(nWords));
    endtask

    // Wait (bounded) for DONE, then linger to catch any duplicate pulse.
    task automatic waitDone(input string tag, input int bound);
        int g = 0;
        while (doneCyc.size() == dBase && g < bound) begin
            tick();
            g++;
        end
        checkOutput({tag, "_done_seen"}, 64'(doneCyc.size() > dBase), 64'(1));
        repeat (3) tick();
        checkOutput({tag, "_done_count"}, 64'(doneCyc.size() - dBase), 64'(1));
    endtask

    function automatic int doneAt();
        return (doneCyc.size() > dBase) ? doneCyc[dBase] : -1;
    endfunction

    function automatic logic doneErrAt();
        return (doneErr.size() > dBase) ? doneErr[dBase] : 1'bx;
    endfunction

    function automatic int lastHs();
        return (hsCyc.size() > 0) ? hsCyc[hsCyc.size()-1] : -1;
    endfunction

    // Reference outcome: sum of (word ^ index) written vs read, modulo 2^CSW.
    function automatic logic modelError(input logic corrupt);
        longint unsigned sw = 0;
        longint unsigned sr = 0;
        longint unsigned mask = (64'd1 << CSW) - 1;
        for (int i = 0; i < N; i++) begin
            sw += 64'(words[i]) ^ 64'(i);
            sr += 64'(words[i] ^ ((corrupt && i == 37) ? DW'(1) : DW'(0))) ^ 64'(i);
        end
        return (sw & mask) != (sr & mask);
    endfunction

    // Writes must be words[0..nExp-1] at addresses 0.. in order, each one cycle after its handshake.
    task automatic checkWrites(input string tag, input int nExp);
        int nW = wrAddr.size() - wBase;
        int bad = 0;
        int badT = 0;
        checkOutput({tag, "_wr_count"}, 64'(nW), 64'(nExp));
        for (int i = 0; i < nW && i < nExp; i++) begin
            if (wrAddr[wBase+i] != i || wrData[wBase+i] !== words[i]) bad++;
            if (i < hsCyc.size() && wrCyc[wBase+i] != hsCyc[i] + 1) badT++;
        end
        checkOutput({tag, "_wr_content_bad"}, 64'(bad), 64'(0));
        checkOutput({tag, "_wr_latency_bad"}, 64'(badT), 64'(0));
    endtask

    // Reads must cover addresses 0..N-1 back-to-back, starting two cycles after the last handshake.
    task automatic checkReads(input string tag);
        int nR = rdAddr.size() - rBase;
        int bad = 0;
        checkOutput({tag, "_rd_count"}, 64'(nR), 64'(N));
        for (int i = 0; i < nR && i < N; i++) begin
            if (rdAddr[rBase+i] != i || rdCyc[rBase+i] != rdCyc[rBase] + i) bad++;
        end
        checkOutput({tag, "_rd_seq_bad"}, 64'(bad), 64'(0));
        checkOutput({tag, "_rd_first_cycle"}, 64'((nR > 0) ? rdCyc[rBase] : -1), 64'(lastHs() + 2));
    endtask

    // Directed sequence of scenarios, each with randomized weight data.
    initial begin
        RSTn = 1'b1; START = 1'b0; VERIFY_EN = 1'b0; ABORT = 1'b0;
        WIN_VALID = 1'b0; WIN_DATA = '0; flip = 1'b0;

        #3 RSTn = 1'b0;
        #1 checkOutput("reset_outputs", outVec(), 64'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK) RSTn = 1'b1;
        tick();

        $display("[TB] load without verify, no stalls");
        genWords(); markLogs();
        doStart(1'b0);
        applyStimulus(0, N);
        waitDone("A", 400);
        checkWrites("A", N);
        checkOutput("A_wen_consecutive",
                    64'((wrAddr.size() - wBase == N) ? wrCyc[wBase+N-1] - wrCyc[wBase] : -1), 64'(N-1));
        checkOutput("A_done_from_start", 64'(doneAt()), 64'(startCyc + N + 2));
        checkOutput("A_done_after_hs", 64'(doneAt()), 64'(lastHs() + 2));
        checkOutput("A_error", 64'(doneErrAt()), 64'(0));
        checkOutput("A_busy_idle", 64'(BUSY), 64'(0));

        $display("[TB] load without verify, random stalls");
        genWords(); markLogs();
        doStart(1'b0);
        applyStimulus(1, N);
        waitDone("B", 4000);
        checkWrites("B", N);
        checkOutput("B_done_after_hs", 64'(doneAt()), 64'(lastHs() + 2));

        $display("[TB] load with verify, clean RAM");
        genWords(); markLogs(); flip = 1'b0;
        doStart(1'b1);
        applyStimulus(0, N);
        waitDone("C", 600);
        checkWrites("C", N);
        checkReads("C");
        checkOutput("C_done_from_start", 64'(doneAt()), 64'(startCyc + 2*N + 4));
        checkOutput("C_error", 64'(doneErrAt()), 64'(modelError(1'b0)));

        $display("[TB] load with verify, corrupted RAM word, random stalls");
        genWords(); markLogs(); flip = 1'b1;
        doStart(1'b1);
        applyStimulus(1, N);
        waitDone("D", 4000);
        checkWrites("D", N);
        checkReads("D");
        checkOutput("D_done_after_hs", 64'(doneAt()), 64'(lastHs() + N + 4));
        checkOutput("D_error_at_done", 64'(doneErrAt()), 64'(modelError(1'b1)));
        repeat (2) tick();
        checkOutput("D_error_sticky", 64'(ERROR), 64'(modelError(1'b1)));
        flip = 1'b0;
        genWords(); markLogs();
        doStart(1'b0);
        checkOutput("D_error_cleared_by_start", 64'(ERROR), 64'(0));
        applyStimulus(0, N);
        waitDone("D2", 400);
        checkOutput("D2_error", 64'(doneErrAt()), 64'(0));

        $display("[TB] abort after 50 handshakes");
        genWords(); markLogs();
        doStart(1'b0);
        applyStimulus(0, 50);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        checkOutput("E_busy_after_abort", 64'(BUSY), 64'(0));
        checkOutput("E_ready_after_abort", 64'(WIN_READY), 64'(0));
        checkOutput("E_wen_after_abort", 64'(WEN), 64'(0));
        repeat (5) tick();
        checkOutput("E_no_done", 64'(doneCyc.size() - dBase), 64'(0));
        checkWrites("E", 50);

        $display("[TB] async reset mid-load, then full reload");
        genWords(); markLogs();
        doStart(1'b0);
        applyStimulus(0, 30);
        #2 RSTn = 1'b0;
        #1 checkOutput("F_reset_outputs", outVec(), 64'(0));
        @(negedge CLK) RSTn = 1'b1;
        tick();
        checkOutput("F_no_done", 64'(doneCyc.size() - dBase), 64'(0));
        genWords(); markLogs();
        doStart(1'b0);
        applyStimulus(1, N);
        waitDone("F", 4000);
        checkWrites("F", N);
        checkOutput("F_first_addr", 64'((wrAddr.size() > wBase) ? wrAddr[wBase] : -1), 64'(0));
        checkOutput("F_error", 64'(doneErrAt()), 64'(0));

        checkOutput("wen_ren_exclusive", 64'(bothCnt), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
